// File: rtl/mem_stage_pkg.sv
// Shared memory-stage types, widths and opcode decode.
// Imported by the MEM stage and reusable by DE/FE stall logic.
package mem_stage_pkg;

  localparam int OPCODE_WIDTH = 8;
  localparam int PC_WIDTH     = 16;
  localparam int IR_WIDTH     = 32;
  localparam int REG_WIDTH    = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_STB = 8'h12;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h13;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic                    lock;
    logic                    valid;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [PC_WIDTH-1:0]     pc;
    logic [IR_WIDTH-1:0]     ir;
    logic [3:0]              dest_idx;
    logic [REG_WIDTH-1:0]    dest_value;
    logic [2:0]              cc_value;
    logic                    reg_wen;
    logic                    cc_wen;
  } mem_wb_t;

  function automatic logic is_mem_op(
    input logic [OPCODE_WIDTH-1:0] op
  );
    return (op == OP_LDB) || (op == OP_LDW) ||
           (op == OP_STB) || (op == OP_STW);
  endfunction

  function automatic logic is_store_op(
    input logic [OPCODE_WIDTH-1:0] op
  );
    return (op == OP_STB) || (op == OP_STW);
  endfunction

  function automatic logic is_byte_op(
    input logic [OPCODE_WIDTH-1:0] op
  );
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port data RAM: async read, byte-enabled write.
// Writes land on the falling edge, matching the stage clocking.
module data_mem_array #(
  parameter int DMEM_ADDR_BITS = 11
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [1:0]                be,
  input  logic [DMEM_ADDR_BITS-2:0] addr,
  input  logic [15:0]               wdata,
  output logic [15:0]               rdata
);

  localparam int WORDS = 1 << (DMEM_ADDR_BITS - 1);

  logic [15:0] mem [WORDS];

  assign rdata = mem[addr];

  // byte-lane writes; unselected lane keeps its contents
  always_ff @(negedge clk) begin
    if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle loads/stores, pass-through
// for everything else, with a combinational stall upstream.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_ADDR_BITS = 11,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic                    I_EX_Valid,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [IR_WIDTH-1:0]     I_IR,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic [2:0]              I_CCValue,
  input  logic                    I_RegWEn,
  input  logic                    I_CCWEn,
  input  logic [REG_WIDTH-1:0]    I_MARValue,
  input  logic [REG_WIDTH-1:0]    I_MDRValue,
  output logic                    O_LOCK,
  output logic                    O_MEM_Valid,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [PC_WIDTH-1:0]     O_PC,
  output logic [IR_WIDTH-1:0]     O_IR,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic [2:0]              O_CCValue,
  output logic                    O_RegWEn,
  output logic                    O_CCWEn,
  output logic                    O_MemStall_Signal,
  output logic                    O_RegWEn_Signal
);

  localparam int         WORD_BITS = DMEM_ADDR_BITS - 1;
  localparam logic [3:0] CNT_INIT  = 4'(MEM_LATENCY - 1);
  localparam logic       ONE_SHOT  = (MEM_LATENCY == 1);

  mem_state_t state;
  logic [3:0] cnt;
  mem_wb_t    wb_q;

  logic                 is_mem;
  logic                 is_store;
  logic                 is_byte;
  logic                 done;
  logic                 wr_en;
  logic [1:0]           wr_be;
  logic [WORD_BITS-1:0] word_idx;
  logic [15:0]          wr_data;
  logic [15:0]          rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          ld_val;
  logic                 unused_mar;

  assign is_mem   = I_EX_Valid & I_LOCK & is_mem_op(I_Opcode);
  assign is_store = is_store_op(I_Opcode);
  assign is_byte  = is_byte_op(I_Opcode);

  assign done = is_mem &
    (ONE_SHOT | ((state == BUSY) & (cnt == 4'd1)));

  assign O_MemStall_Signal = is_mem & ~done;
  assign O_RegWEn_Signal   = I_EX_Valid & I_RegWEn & I_LOCK;

  assign word_idx   = I_MARValue[DMEM_ADDR_BITS-1:1];
  assign unused_mar = ^I_MARValue;

  assign rd_byte = I_MARValue[0] ? rd_word[15:8]
                                 : rd_word[7:0];
  assign ld_val  = is_byte ? {{8{rd_byte[7]}}, rd_byte}
                           : rd_word;

  assign wr_en   = done & is_store & ~I_RESET;
  assign wr_be   = ~is_byte      ? 2'b11 :
                   I_MARValue[0] ? 2'b10 : 2'b01;
  assign wr_data = is_byte ? {2{I_MDRValue[7:0]}}
                           : I_MDRValue;

  data_mem_array #(
    .DMEM_ADDR_BITS(DMEM_ADDR_BITS)
  ) u_dmem (
    .clk  (I_CLOCK),
    .we   (wr_en),
    .be   (wr_be),
    .addr (word_idx),
    .wdata(wr_data),
    .rdata(rd_word)
  );

  // access FSM plus registered write-back bundle
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state <= IDLE;
      cnt   <= '0;
      wb_q  <= '0;
    end else begin
      wb_q.lock     <= I_LOCK;
      wb_q.opcode   <= I_Opcode;
      wb_q.pc       <= I_PC;
      wb_q.ir       <= I_IR;
      wb_q.dest_idx <= I_DestRegIdx;
      wb_q.cc_value <= I_CCValue;
      wb_q.valid    <= I_LOCK & I_EX_Valid &
                       (~is_mem | done);
      wb_q.reg_wen  <= I_LOCK & (is_mem ?
                       (done & ~is_store & I_RegWEn) :
                       I_RegWEn);
      wb_q.cc_wen   <= I_LOCK & (is_mem ?
                       (done & I_CCWEn) : I_CCWEn);
      wb_q.dest_value <= (done & ~is_store) ? ld_val
                                            : I_DestValue;
      if (I_LOCK) begin
        unique case (state)
          IDLE: begin
            if (is_mem & ~ONE_SHOT) begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
          BUSY: begin
            if (is_mem & ~done) begin
              cnt <= cnt - 4'd1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign O_LOCK       = wb_q.lock;
  assign O_MEM_Valid  = wb_q.valid;
  assign O_Opcode     = wb_q.opcode;
  assign O_PC         = wb_q.pc;
  assign O_IR         = wb_q.ir;
  assign O_DestRegIdx = wb_q.dest_idx;
  assign O_DestValue  = wb_q.dest_value;
  assign O_CCValue    = wb_q.cc_value;
  assign O_RegWEn     = wb_q.reg_wen;
  assign O_CCWEn      = wb_q.cc_wen;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: four lanes at latencies 1/2/4/5,
// a per-lane reference model and directed literal checks.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int NL = 4;
  localparam int AB = 11;
  localparam int NW = 1 << (AB - 1);

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 5;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    = 1'b1;
  logic        lock   = 1'b1;
  logic        valid  = 1'b0;
  logic [7:0]  opcode = OP_NOP;
  logic [15:0] pc     = '0;
  logic [31:0] ir     = '0;
  logic [3:0]  idx    = '0;
  logic [15:0] dval   = '0;
  logic [2:0]  cc     = 3'b010;
  logic        rwen   = 1'b1;
  logic        ccwen  = 1'b1;
  logic [15:0] mar    = '0;
  logic [15:0] mdr    = '0;
  int          sel    = 1;

  logic [NL-1:0] lk;
  logic [NL-1:0] o_lock, o_valid, o_rwen, o_ccwen;
  logic [NL-1:0] o_stall, o_rwsig;
  logic [7:0]    o_op   [NL];
  logic [15:0]   o_pc   [NL];
  logic [31:0]   o_ir   [NL];
  logic [3:0]    o_idx  [NL];
  logic [15:0]   o_dval [NL];
  logic [2:0]    o_cc   [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign lk[g] = lock & (sel == g);
    mem_access_stage #(
      .DMEM_ADDR_BITS(AB),
      .MEM_LATENCY(lat_of(g))
    ) u_dut (
      .I_CLOCK          (clk),
      .I_RESET          (rst),
      .I_LOCK           (lk[g]),
      .I_EX_Valid       (valid),
      .I_Opcode         (opcode),
      .I_PC             (pc),
      .I_IR             (ir),
      .I_DestRegIdx     (idx),
      .I_DestValue      (dval),
      .I_CCValue        (cc),
      .I_RegWEn         (rwen),
      .I_CCWEn          (ccwen),
      .I_MARValue       (mar),
      .I_MDRValue       (mdr),
      .O_LOCK           (o_lock[g]),
      .O_MEM_Valid      (o_valid[g]),
      .O_Opcode         (o_op[g]),
      .O_PC             (o_pc[g]),
      .O_IR             (o_ir[g]),
      .O_DestRegIdx     (o_idx[g]),
      .O_DestValue      (o_dval[g]),
      .O_CCValue        (o_cc[g]),
      .O_RegWEn         (o_rwen[g]),
      .O_CCWEn          (o_ccwen[g]),
      .O_MemStall_Signal(o_stall[g]),
      .O_RegWEn_Signal  (o_rwsig[g])
    );
  end

  typedef struct {
    logic        lock, valid, rwen, ccwen;
    logic [7:0]  op;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [3:0]  idx;
    logic [15:0] dval;
    logic [2:0]  cc;
    int          lvl;
    bit          dv;
  } exp_t;

  logic [15:0] mm    [NL][NW];
  int          held  [NL];
  bit          armed [NL];
  exp_t        ex    [NL];
  int vectors    = 0;
  int miscompares = 0;

  initial begin
    for (int g = 0; g < NL; g++) begin
      held[g]   = 0;
      armed[g]  = 1'b0;
      ex[g].lvl = -1;
    end
  end

  task automatic cmp(input string nm, input int g,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s lane%0d: got %h want %h @%0t",
               nm, g, act, req, $time);
    end
  endtask

  // model: an op completes on its LAT-th accepted presentation
  task automatic step_lane(input int g);
    logic        l, m, fin;
    int          k, w;
    logic [15:0] word;
    logic [7:0]  b;
    l   = lk[g];
    m   = valid && l && (opcode inside
          {OP_LDB, OP_LDW, OP_STB, OP_STW});
    k   = held[g] + 1;
    fin = m && (k >= lat_of(g));
    w   = (int'(mar) >> 1) % NW;
    if (armed[g]) begin
      cmp("stall", g, 32'(o_stall[g]), 32'(m && !fin));
      cmp("regwen_sig", g, 32'(o_rwsig[g]),
          32'(valid & rwen & l));
    end
    if (rst) begin
      held[g] = 0;
      armed[g] = 1'b1;
      ex[g] = '{lock: 0, valid: 0, rwen: 0, ccwen: 0,
                op: 0, pc: 0, ir: 0, idx: 0, dval: 0,
                cc: 0, lvl: 2, dv: 1};
    end else if (!l) begin
      ex[g].lock = 0; ex[g].valid = 0;
      ex[g].rwen = 0; ex[g].ccwen = 0;
      ex[g].lvl  = 1;
    end else if (m && !fin) begin
      held[g] = k;
      ex[g].lock = 1; ex[g].valid = 0;
      ex[g].lvl  = 0;
    end else begin
      held[g] = 0;
      ex[g] = '{lock: 1, valid: valid, rwen: rwen,
                ccwen: ccwen, op: opcode, pc: pc, ir: ir,
                idx: idx, dval: dval, cc: cc, lvl: 2, dv: 1};
      if (m) begin
        word = mm[g][w];
        b    = mar[0] ? word[15:8] : word[7:0];
        case (opcode)
          OP_LDW: ex[g].dval = word;
          OP_LDB: ex[g].dval =
                  16'(int'(b) - (int'(b) >= 128 ? 256 : 0));
          OP_STW: mm[g][w] = mdr;
          default: mm[g][w] = mar[0] ? {mdr[7:0], word[7:0]}
                                     : {word[15:8], mdr[7:0]};
        endcase
        if (opcode inside {OP_STB, OP_STW}) begin
          ex[g].rwen = 0;
          ex[g].dv   = 0;
        end else if ($isunknown(word)) begin
          ex[g].dv = 0;
        end
      end
    end
  endtask

  task automatic check_lane(input int g);
    if (ex[g].lvl >= 0) begin
      cmp("o_lock", g, 32'(o_lock[g]), 32'(ex[g].lock));
      cmp("o_valid", g, 32'(o_valid[g]), 32'(ex[g].valid));
      if (ex[g].lvl >= 1) begin
        cmp("o_regwen", g, 32'(o_rwen[g]), 32'(ex[g].rwen));
        cmp("o_ccwen", g, 32'(o_ccwen[g]), 32'(ex[g].ccwen));
      end
      if (ex[g].lvl >= 2) begin
        cmp("o_opcode", g, 32'(o_op[g]), 32'(ex[g].op));
        cmp("o_pc", g, 32'(o_pc[g]), 32'(ex[g].pc));
        cmp("o_ir", g, o_ir[g], ex[g].ir);
        cmp("o_idx", g, 32'(o_idx[g]), 32'(ex[g].idx));
        cmp("o_cc", g, 32'(o_cc[g]), 32'(ex[g].cc));
        if (ex[g].dv)
          cmp("o_dval", g, 32'(o_dval[g]), 32'(ex[g].dval));
      end
    end
  endtask

  // compare process: comb outputs mid-cycle, regs after the edge
  always @(posedge clk) begin
    #3;
    for (int g = 0; g < NL; g++) step_lane(g);
    #5;
    for (int g = 0; g < NL; g++) check_lane(g);
  end

  task automatic drive(input logic [7:0] opc,
                       input logic [15:0] a,
                       input logic [15:0] d,
                       input logic [3:0] ri);
    valid  = 1'b1;
    opcode = opc;
    mar    = a;
    mdr    = d;
    dval   = d;
    idx    = ri;
    ir     = {16'hA5A5, pc};
  endtask

  // upstream model: hold the op for its full latency
  task automatic op(input int g, input logic [7:0] opc,
                    input logic [15:0] a,
                    input logic [15:0] d,
                    input logic [3:0] ri, output int st);
    int n;
    n  = (opc inside {OP_LDB, OP_LDW, OP_STB, OP_STW})
         ? lat_of(g) : 1;
    st = 0;
    pc = pc + 16'd2;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      sel  = g;
      lock = 1'b1;
      drive(opc, a, d, ri);
      #4;
      st += int'(o_stall[g]);
    end
    #4;
  endtask

  task automatic gap();
    @(posedge clk);
    valid = 1'b0;
    #8;
  endtask

  int st;

  initial begin
    @(posedge clk);
    @(posedge clk);
    #4;
    cmp("rst_lock", 1, 32'(o_lock[1]), 32'd0);
    cmp("rst_valid", 1, 32'(o_valid[1]), 32'd0);
    cmp("rst_dval", 1, 32'(o_dval[1]), 32'd0);
    @(posedge clk);
    rst = 1'b0;
    #8;

    op(1, OP_STW, 16'h0010, 16'hBEEF, 4'd1, st);
    cmp("stw_stall_cycles", 1, 32'(st), 32'd1);
    op(1, OP_LDW, 16'h0010, 16'h0000, 4'd3, st);
    cmp("ldw_stall_cycles", 1, 32'(st), 32'd1);
    cmp("ldw_val", 1, 32'(o_dval[1]), 32'hBEEF);
    cmp("ldw_regwen", 1, 32'(o_rwen[1]), 32'd1);
    cmp("ldw_idx", 1, 32'(o_idx[1]), 32'd3);

    op(1, OP_STW, 16'h0020, 16'h1234, 4'd1, st);
    op(1, OP_STB, 16'h0021, 16'h00AB, 4'd1, st);
    op(1, OP_LDW, 16'h0020, 16'h0000, 4'd4, st);
    cmp("byte_merge", 1, 32'(o_dval[1]), 32'hAB34);
    op(1, OP_LDB, 16'h0021, 16'h0000, 4'd5, st);
    cmp("ldb_hi_sext", 1, 32'(o_dval[1]), 32'hFFAB);
    op(1, OP_LDB, 16'h0020, 16'h0000, 4'd6, st);
    cmp("ldb_lo", 1, 32'(o_dval[1]), 32'h0034);
    gap();

    op(2, OP_ADD, 16'h0000, 16'h0007, 4'd5, st);
    cmp("add_stall_cycles", 2, 32'(st), 32'd0);
    cmp("add_val", 2, 32'(o_dval[2]), 32'd7);
    cmp("add_valid", 2, 32'(o_valid[2]), 32'd1);
    gap();

    op(0, OP_STW, 16'h0008, 16'h0C0C, 4'd1, st);
    op(0, OP_LDW, 16'h0008, 16'h0000, 4'd2, st);
    cmp("lat1_stall_cycles", 0, 32'(st), 32'd0);
    cmp("lat1_val", 0, 32'(o_dval[0]), 32'h0C0C);
    gap();
    op(3, OP_STW, 16'h0008, 16'h3C3C, 4'd1, st);
    op(3, OP_LDW, 16'h0008, 16'h0000, 4'd2, st);
    cmp("lat5_stall_cycles", 3, 32'(st), 32'd4);
    cmp("lat5_val", 3, 32'(o_dval[3]), 32'h3C3C);
    gap();

    op(3, OP_STW, 16'h0040, 16'h1111, 4'd1, st);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      sel = 3;
      drive(OP_STW, 16'h0040, 16'h5555, 4'd1);
      rst = (k == 2);
    end
    @(posedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    #4;
    cmp("post_rst_stall", 3, 32'(o_stall[3]), 32'd0);
    cmp("post_rst_valid", 3, 32'(o_valid[3]), 32'd0);
    cmp("post_rst_lock", 3, 32'(o_lock[3]), 32'd0);
    cmp("post_rst_dval", 3, 32'(o_dval[3]), 32'd0);
    #4;
    op(3, OP_LDW, 16'h0040, 16'h0000, 4'd7, st);
    cmp("abandoned_store", 3, 32'(o_dval[3]), 32'h1111);
    cmp("post_rst_stall_cycles", 3, 32'(st), 32'd4);
    gap();

    op(1, OP_STW, 16'h0030, 16'h0101, 4'd1, st);
    @(posedge clk);
    lock = 1'b0;
    drive(OP_STW, 16'h0030, 16'h7777, 4'd1);
    #4;
    cmp("locked_stall", 1, 32'(o_stall[1]), 32'd0);
    #4;
    cmp("locked_valid", 1, 32'(o_valid[1]), 32'd0);
    op(1, OP_LDW, 16'h0030, 16'h0000, 4'd8, st);
    cmp("locked_no_write", 1, 32'(o_dval[1]), 32'h0101);

    op(1, OP_STW, 16'h0802, 16'h9A9A, 4'd1, st);
    op(1, OP_LDW, 16'h0002, 16'h0000, 4'd9, st);
    cmp("addr_wrap", 1, 32'(o_dval[1]), 32'h9A9A);
    gap();
    gap();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
